// File: rtl/scale_engine.sv
`default_nettype none
// ============================================================================
//  Module   : scale_engine
//  Purpose  : Power-of-two image scaler. Reads a SRC_W x SRC_H source image
//             from a synchronous ROM and writes the scaled result, centred,
//             into a DST_W x DST_H frame RAM. Modes: copy, replicate (zoom
//             in), decimate and block average (zoom out), factor F = 2^k.
//  Ports    : clk, reset (async, active-low)
//             start/abort/mode/log2f  - job request and control
//             busy/done/err           - job status (done/err are levels)
//             rom_addr/rom_data       - source ROM, data one cycle after addr
//             ram_wraddr/ram_data/ram_wren - destination RAM write port
//  Revision : 1.0 - initial release
// ============================================================================
module scale_engine #(
   parameter int SRC_W     = 160,
   parameter int SRC_H     = 120,
   parameter int DST_W     = 640,
   parameter int DST_H     = 480,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 19,
   parameter int MAX_LOG2F = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               abort,
   input  logic [1:0]                         mode,
   input  logic [$clog2(MAX_LOG2F+1)-1:0]     log2f,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic [ADDR_W-1:0]                  rom_addr,
   input  logic [DATA_W-1:0]                  rom_data,
   output logic [ADDR_W-1:0]                  ram_wraddr,
   output logic [DATA_W-1:0]                  ram_data,
   output logic                               ram_wren
);

   localparam int K_W   = $clog2(MAX_LOG2F + 1);
   // F*F samples of at most 2^DATA_W-1 each always fit in this width.
   localparam int ACC_W = DATA_W + 2 * MAX_LOG2F;

   localparam logic [1:0] MODE_COPY = 2'd0;
   localparam logic [1:0] MODE_REP  = 2'd1;
   localparam logic [1:0] MODE_DEC  = 2'd2;
   localparam logic [1:0] MODE_AVG  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_RD    = 3'd2,
      S_WR    = 3'd3,
      S_ACC   = 3'd4,
      S_AWR   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [ADDR_W-1:0]   out_w_q, out_w_d, out_h_q, out_h_d;
   logic [ADDR_W-1:0]   off_x_q, off_x_d, off_y_q, off_y_d;
   logic [ADDR_W-1:0]   ox_q, ox_d, oy_q, oy_d;
   logic [ADDR_W-1:0]   bx_q, bx_d, by_q, by_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                done_q, done_d, err_q, err_d;

   // Output geometry for the latched request (evaluated in CHECK).
   logic [31:0] chk_w, chk_h;
   logic        chk_bad;

   always_comb begin
      chk_w = 32'(SRC_W);
      chk_h = 32'(SRC_H);
      if (mode_q == MODE_REP) begin
         chk_w = 32'(SRC_W) << k_q;
         chk_h = 32'(SRC_H) << k_q;
      end else if (mode_q == MODE_DEC || mode_q == MODE_AVG) begin
         chk_w = 32'(SRC_W) >> k_q;
         chk_h = 32'(SRC_H) >> k_q;
      end
   end

   assign chk_bad = (32'(k_q) > 32'(MAX_LOG2F)) || (chk_w > 32'(DST_W)) ||
                    (chk_h > 32'(DST_H));

   // Source coordinates of the sample addressed this cycle.
   logic [ADDR_W-1:0] sx, sy;

   always_comb begin
      sx = ox_q;
      sy = oy_q;
      case (mode_q)
         MODE_REP: begin
            sx = ox_q >> k_q;
            sy = oy_q >> k_q;
         end
         MODE_DEC: begin
            sx = ox_q << k_q;
            sy = oy_q << k_q;
         end
         MODE_AVG: begin
            sx = (ox_q << k_q) + bx_q;
            sy = (oy_q << k_q) + by_q;
         end
         default: begin
            sx = ox_q;
            sy = oy_q;
         end
      endcase
   end

   logic [ADDR_W-1:0] blk_last;
   logic [ACC_W-1:0]  sum;
   logic              last_x, last_y, blk_first;

   assign blk_last  = (ADDR_W'(1) << k_q) - ADDR_W'(1);
   assign last_x    = (ox_q == out_w_q - ADDR_W'(1));
   assign last_y    = (oy_q == out_h_q - ADDR_W'(1));
   assign blk_first = (bx_q == '0) && (by_q == '0);
   // ROM data always belongs to the address issued one cycle earlier, so the
   // last sample of a block is only available during AWR itself.
   assign sum       = acc_q + ACC_W'(rom_data);

   // Outputs are decoded from registered state only (plus the ROM register).
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign ram_wren   = (state_q == S_WR) || (state_q == S_AWR);
   assign rom_addr   = ((state_q == S_RD) || (state_q == S_ACC)) ?
                       sy * ADDR_W'(SRC_W) + sx : '0;
   assign ram_wraddr = ram_wren ?
                       (off_y_q + oy_q) * ADDR_W'(DST_W) + off_x_q + ox_q : '0;

   always_comb begin
      ram_data = '0;
      if (state_q == S_WR) begin
         ram_data = rom_data;
      end else if (state_q == S_AWR) begin
         ram_data = DATA_W'(sum >> {k_q, 1'b0});
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      k_d     = k_q;
      out_w_d = out_w_q;
      out_h_d = out_h_q;
      off_x_d = off_x_q;
      off_y_d = off_y_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      bx_d    = bx_q;
      by_d    = by_q;
      acc_d   = acc_q;
      done_d  = done_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               k_d     = log2f;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (chk_bad) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               out_w_d = ADDR_W'(chk_w);
               out_h_d = ADDR_W'(chk_h);
               off_x_d = ADDR_W'((32'(DST_W) - chk_w) >> 1);
               off_y_d = ADDR_W'((32'(DST_H) - chk_h) >> 1);
               ox_d    = '0;
               oy_d    = '0;
               bx_d    = '0;
               by_d    = '0;
               state_d = (mode_q == MODE_AVG) ? S_ACC : S_RD;
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_ACC: begin
            acc_d = blk_first ? '0 : sum;
            if (bx_q == blk_last) begin
               bx_d = '0;
               if (by_q == blk_last) begin
                  by_d    = '0;
                  state_d = S_AWR;
               end else begin
                  by_d = by_q + ADDR_W'(1);
               end
            end else begin
               bx_d = bx_q + ADDR_W'(1);
            end
         end
         S_WR, S_AWR: begin
            if (last_x) begin
               ox_d = '0;
               if (last_y) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  oy_d    = oy_q + ADDR_W'(1);
                  state_d = (state_q == S_AWR) ? S_ACC : S_RD;
               end
            end else begin
               ox_d    = ox_q + ADDR_W'(1);
               state_d = (state_q == S_AWR) ? S_ACC : S_RD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over completion and rejection; a write already on the
      // port this cycle is unaffected because ram_wren is decoded from state.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         k_q     <= '0;
         out_w_q <= '0;
         out_h_q <= '0;
         off_x_q <= '0;
         off_y_q <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         k_q     <= k_d;
         out_w_q <= out_w_d;
         out_h_q <= out_h_d;
         off_x_q <= off_x_d;
         off_y_q <= off_y_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scale_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scale_engine
//  Purpose  : Self-checking bench for scale_engine (SRC 8x4, DST 32x16,
//             MAX_LOG2F 2). A behavioural model derives every expected RAM
//             write and the job length from the scaling rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scale_engine;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [1:0]  mode, log2f;
   logic        busy, done, err, ram_wren;
   logic [18:0] rom_addr, ram_wraddr;
   logic [7:0]  rom_data, ram_data;

   logic [7:0]  rom_mem [32];
   logic [31:0] got_addr[$], got_data[$];
   int          exp_addr[$], exp_data[$];
   int          exp_cycles;
   bit          exp_rej;
   int          n_cmp = 0;
   int          n_bad = 0;

   scale_engine #(
      .SRC_W(8), .SRC_H(4), .DST_W(32), .DST_H(16),
      .DATA_W(8), .ADDR_W(19), .MAX_LOG2F(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .mode(mode), .log2f(log2f), .busy(busy), .done(done), .err(err),
      .rom_addr(rom_addr), .rom_data(rom_data), .ram_wraddr(ram_wraddr),
      .ram_data(ram_data), .ram_wren(ram_wren)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data for an address appears after the next edge.
   always @(posedge clk) rom_data <= (rom_addr < 19'd32) ? rom_mem[rom_addr[4:0]] : 8'hee;

   function automatic void rom_ramp();
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i);
   endfunction

   // Reference: expected writes in raster order plus the cycle count from the
   // start-sampling edge to done (one CHECK cycle plus per-pixel cost).
   function automatic void build_model(input int m, input int k);
      int f, ow, oh, offx, offy, v;
      exp_addr.delete();
      exp_data.delete();
      f = 1 << k;
      if (m == 0) begin ow = 8; oh = 4; end
      else if (m == 1) begin ow = 8 * f; oh = 4 * f; end
      else begin ow = 8 / f; oh = 4 / f; end
      exp_rej    = (k > 2) || (ow > 32) || (oh > 16);
      exp_cycles = 1;
      if (exp_rej) return;
      offx = (32 - ow) / 2;
      offy = (16 - oh) / 2;
      for (int oy = 0; oy < oh; oy++) begin
         for (int ox = 0; ox < ow; ox++) begin
            if (m == 0) v = int'(rom_mem[oy * 8 + ox]);
            else if (m == 1) v = int'(rom_mem[(oy / f) * 8 + ox / f]);
            else if (m == 2) v = int'(rom_mem[(oy * f) * 8 + ox * f]);
            else begin
               v = 0;
               for (int by = 0; by < f; by++)
                  for (int bx = 0; bx < f; bx++)
                     v += int'(rom_mem[(oy * f + by) * 8 + ox * f + bx]);
               v = v / (f * f);
            end
            exp_addr.push_back((offy + oy) * 32 + offx + ox);
            exp_data.push_back(v);
            exp_cycles += (m == 3) ? (f * f + 1) : 2;
         end
      end
   endfunction

   // Issue a job and record writes until done/err (bounded). n_done is the
   // number of edges after the start-sampling edge at which done is seen.
   // poke_at >= 0 pulses a conflicting start while the job is busy.
   task automatic run_job(input logic [1:0] m, input logic [1:0] k, input int poke_at, output int n_done);
      int n;
      got_addr.delete();
      got_data.delete();
      @(negedge clk);
      mode = m; log2f = k; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom); log2f = 2'($urandom);
      n = 0;
      while (!(done || err) && n < 3000) begin
         if (ram_wren) begin
            got_addr.push_back(32'(ram_wraddr));
            got_data.push_back(32'(ram_data));
         end
         @(negedge clk);
         n++;
         start = (n == poke_at);
         if (start) begin mode = 2'd2; log2f = 2'd2; end
      end
      start = 1'b0;
      n_done = n;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; log2f = 2'd0;
      #1;
      n_cmp++;
      if ({busy, done, err, ram_wren} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, ram_wren});
      end
      n_cmp++;
      if (rom_addr !== 19'd0 || ram_wraddr !== 19'd0 || ram_data !== 8'd0) begin
         n_bad++; $display("FAIL reset_buses: got %0d/%0d/%0d want 0/0/0", rom_addr, ram_wraddr, ram_data);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_copy();
      int n;
      rom_ramp();
      build_model(0, 1);
      run_job(2'd0, 2'd1, -1, n);
      n_cmp++;
      if (n !== 65) begin n_bad++; $display("FAIL copy_done_cycle: got %0d want 65", n); end
      n_cmp++;
      if (got_addr.size() != 32) begin n_bad++; $display("FAIL copy_count: got %0d want 32", got_addr.size()); end
      else begin
         n_cmp++;
         if (got_addr[0] !== 204 || got_data[0] !== 0 || got_addr[31] !== 307 || got_data[31] !== 31) begin
            n_bad++; $display("FAIL copy_ends: got (%0d,%0d)..(%0d,%0d) want (204,0)..(307,31)", got_addr[0], got_data[0], got_addr[31], got_data[31]);
         end
      end
      foreach (exp_addr[i]) if (i < got_addr.size()) begin
         n_cmp++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL copy_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_replicate();
      int n;
      int ram [512];
      rom_ramp();
      build_model(1, 1);
      run_job(2'd1, 2'd1, -1, n);
      for (int i = 0; i < 512; i++) ram[i] = -1;
      foreach (got_addr[i]) if (got_addr[i] < 512) ram[got_addr[i]] = int'(got_data[i]);
      n_cmp++;
      if (n !== 257) begin n_bad++; $display("FAIL rep_done_cycle: got %0d want 257", n); end
      n_cmp++;
      if (got_addr.size() != 128) begin n_bad++; $display("FAIL rep_count: got %0d want 128", got_addr.size()); end
      n_cmp++;
      if (ram[136] !== 0 || ram[137] !== 0 || ram[168] !== 0 || ram[138] !== 1) begin
         n_bad++; $display("FAIL rep_points: got %0d %0d %0d %0d want 0 0 0 1", ram[136], ram[137], ram[168], ram[138]);
      end
      foreach (exp_addr[i]) if (i < got_addr.size()) begin
         n_cmp++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL rep_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_decimate();
      int n;
      rom_ramp();
      run_job(2'd2, 2'd2, -1, n);
      n_cmp++;
      if (got_addr.size() != 2) begin n_bad++; $display("FAIL dec_count: got %0d want 2", got_addr.size()); end
      else begin
         n_cmp++;
         if (got_addr[0] !== 239 || got_data[0] !== 0 || got_addr[1] !== 240 || got_data[1] !== 4) begin
            n_bad++; $display("FAIL dec_writes: got (%0d,%0d),(%0d,%0d) want (239,0),(240,4)", got_addr[0], got_data[0], got_addr[1], got_data[1]);
         end
      end
      n_cmp++;
      if (n !== 5) begin n_bad++; $display("FAIL dec_done_cycle: got %0d want 5", n); end
   endtask

   task automatic test_average();
      int n;
      rom_ramp();
      rom_mem[0] = 8'd10; rom_mem[1] = 8'd20; rom_mem[8] = 8'd30; rom_mem[9] = 8'd41;
      build_model(3, 1);
      run_job(2'd3, 2'd1, -1, n);
      n_cmp++;
      if (got_addr.size() == 0 || got_addr[0] !== 238 || got_data[0] !== 25) begin
         n_bad++; $display("FAIL avg_first: got %0d writes, first (%0d,%0d) want (238,25)", got_addr.size(), got_addr.size() ? got_addr[0] : 0, got_data.size() ? got_data[0] : 0);
      end
      n_cmp++;
      if (n !== 41) begin n_bad++; $display("FAIL avg_done_cycle: got %0d want 41 (5 per pixel)", n); end
      n_cmp++;
      if (got_addr.size() != exp_addr.size()) begin n_bad++; $display("FAIL avg_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
      foreach (exp_addr[i]) if (i < got_addr.size()) begin
         n_cmp++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL avg_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_reject();
      int n;
      rom_ramp();
      // Flags appear after the single CHECK cycle, i.e. in the second cycle
      // counting the start cycle as the first.
      run_job(2'd1, 2'd3, -1, n);
      n_cmp++;
      if (n !== 1 || err !== 1'b1 || done !== 1'b1) begin
         n_bad++; $display("FAIL rej_flags: got n=%0d err=%b done=%b want n=1 err=1 done=1", n, err, done);
      end
      n_cmp++;
      if (got_addr.size() != 0 || ram_wren !== 1'b0) begin n_bad++; $display("FAIL rej_writes: got %0d want 0", got_addr.size()); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rej_busy: got %b want 0", busy); end
      run_job(2'd0, 2'd0, -1, n);
      n_cmp++;
      if (err !== 1'b0 || done !== 1'b1 || n !== 65) begin
         n_bad++; $display("FAIL rej_clear: got err=%b done=%b n=%0d want err=0 done=1 n=65", err, done, n);
      end
   endtask

   task automatic test_abort();
      int n, wr;
      rom_ramp();
      @(negedge clk);
      mode = 2'd1; log2f = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; wr = 0;
      while (n < 500 && !abort) begin
         @(negedge clk);
         n++;
         if (ram_wren) begin
            wr++;
            if (wr == 10) abort = 1'b1;
         end
      end
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_bad++; $display("FAIL abort_flags: got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
      end
      repeat (30) begin
         if (ram_wren) wr++;
         @(negedge clk);
      end
      n_cmp++;
      if (wr !== 10) begin n_bad++; $display("FAIL abort_writes: got %0d want 10", wr); end
   endtask

   task automatic test_reset_mid();
      int n, wr;
      rom_ramp();
      @(negedge clk);
      mode = 2'd3; log2f = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, err, ram_wren} !== 4'b0000 || rom_addr !== 19'd0 || ram_wraddr !== 19'd0 || ram_data !== 8'd0) begin
         n_bad++; $display("FAIL rstmid_outputs: got flags %b addr %0d/%0d data %0d want all 0", {busy, done, err, ram_wren}, rom_addr, ram_wraddr, ram_data);
      end
      wr = 0;
      repeat (4) begin
         @(negedge clk);
         if (ram_wren) wr++;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ram_wren || busy) wr++;
      end
      n_cmp++;
      if (wr !== 0) begin n_bad++; $display("FAIL rstmid_resume: got %0d active cycles want 0", wr); end
      build_model(3, 1);
      run_job(2'd3, 2'd1, -1, n);
      n_cmp++;
      if (n !== exp_cycles || got_addr.size() != exp_addr.size()) begin
         n_bad++; $display("FAIL rstmid_rerun: got n=%0d writes=%0d want n=%0d writes=%0d", n, got_addr.size(), exp_cycles, exp_addr.size());
      end
      foreach (exp_addr[i]) if (i < got_addr.size()) begin
         n_cmp++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL rstmid_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
      build_model(1, 2);
      run_job(2'd1, 2'd2, 20, n);
      n_cmp++;
      if (n !== exp_cycles || got_addr.size() != exp_addr.size()) begin
         n_bad++; $display("FAIL busy_start: got n=%0d writes=%0d want n=%0d writes=%0d", n, got_addr.size(), exp_cycles, exp_addr.size());
      end
      foreach (exp_addr[i]) if (i < got_addr.size()) begin
         n_cmp++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL busy_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_random();
      int n, m, k;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
         m = $urandom_range(0, 3);
         k = $urandom_range(0, 3);
         build_model(m, k);
         run_job(2'(m), 2'(k), -1, n);
         n_cmp++;
         if (n !== exp_cycles || err !== exp_rej || done !== 1'b1 || got_addr.size() != exp_addr.size()) begin
            n_bad++; $display("FAIL rand%0d_job(m=%0d k=%0d): got n=%0d err=%b done=%b writes=%0d want n=%0d err=%b done=1 writes=%0d", it, m, k, n, err, done, got_addr.size(), exp_cycles, exp_rej, exp_addr.size());
         end
         foreach (exp_addr[i]) if (i < got_addr.size()) begin
            n_cmp++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
               n_bad++; $display("FAIL rand%0d_wr[%0d]: got (%0d,%0d) want (%0d,%0d)", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_replicate();
      test_decimate();
      test_average();
      test_reject();
      test_abort();
      test_reset_mid();
      test_busy_ignore();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
